// File: rtl/mpi_ahb3_bridge.sv
// AHB3-Lite slave front end that turns pipelined AHB transfers into the single-request MPI
// bus_en/bus_ack/bus_err handshake. Optional ACCESS watchdog: MPI_AHB3_BRIDGE_TIMEOUT_EN.
module mpi_ahb3_bridge #(
  parameter int unsigned PLEN    = 32,
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ahb3_hsel_i,
  input  logic [PLEN-1:0] ahb3_haddr_i,
  input  logic [XLEN-1:0] ahb3_hwdata_i,
  input  logic            ahb3_hwrite_i,
  input  logic [2:0]      ahb3_hsize_i,
  input  logic [2:0]      ahb3_hburst_i,
  input  logic [3:0]      ahb3_hprot_i,
  input  logic [1:0]      ahb3_htrans_i,
  input  logic            ahb3_hmastlock_i,
  output logic [XLEN-1:0] ahb3_hrdata_o,
  output logic            ahb3_hready_o,
  output logic            ahb3_hresp_o,
  output logic [31:0]     bus_addr,
  output logic            bus_we,
  output logic            bus_en,
  output logic [31:0]     bus_data_in,
  input  logic [31:0]     bus_data_out,
  input  logic            bus_ack,
  input  logic            bus_err
);

  typedef enum logic [2:0] {StIdle, StAccess, StResp, StErr1, StErr2} state_e;

  state_e          state_q, state_d;
  logic [31:0]     addr_q, addr_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            accept;
  logic            misaligned;

`ifdef MPI_AHB3_BRIDGE_TIMEOUT_EN
  logic [15:0] tmo_q, tmo_d;
  logic        unused_sigs;
  assign unused_sigs = ^{ahb3_hburst_i, ahb3_hprot_i, ahb3_hmastlock_i, ahb3_haddr_i};
`else
  logic unused_sigs;
  assign unused_sigs = ^{ahb3_hburst_i, ahb3_hprot_i, ahb3_hmastlock_i, ahb3_haddr_i,
                         16'(TIMEOUT)};
`endif

  // hready_o depends only on state, so using it here forms no combinational loop
  assign accept     = ahb3_hsel_i & ahb3_htrans_i[1] & ahb3_hready_o;
  assign misaligned = (ahb3_hsize_i > 3'd2)
                    | ((ahb3_hsize_i == 3'd1) & ahb3_haddr_i[0])
                    | ((ahb3_hsize_i == 3'd2) & (ahb3_haddr_i[1:0] != 2'b00));

  assign bus_addr      = addr_q;
  assign bus_we        = we_q;
  assign bus_data_in   = ahb3_hwdata_i[31:0];
  assign ahb3_hrdata_o = rdata_q;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    we_d          = we_q;
    rdata_d       = rdata_q;
    ahb3_hready_o = 1'b1;
    ahb3_hresp_o  = 1'b0;
    bus_en        = 1'b0;
`ifdef MPI_AHB3_BRIDGE_TIMEOUT_EN
    tmo_d         = '0;
`endif
    unique case (state_q)
      StIdle, StResp, StErr2: begin
        ahb3_hresp_o = (state_q == StErr2);
        if (accept) begin
          addr_d  = ahb3_haddr_i[31:0];
          we_d    = ahb3_hwrite_i;
          state_d = misaligned ? StErr1 : StAccess;
        end else begin
          state_d = StIdle;
        end
      end
      StAccess: begin
        ahb3_hready_o = 1'b0;
        bus_en        = 1'b1;
`ifdef MPI_AHB3_BRIDGE_TIMEOUT_EN
        tmo_d         = tmo_q + 16'd1;
`endif
        // error wins over a simultaneous ack and leaves read data untouched
        if (bus_err) begin
          state_d = StErr1;
        end else if (bus_ack) begin
          state_d = StResp;
          if (!we_q) rdata_d = bus_data_out;
`ifdef MPI_AHB3_BRIDGE_TIMEOUT_EN
        end else if (tmo_q == 16'(TIMEOUT - 1)) begin
          state_d = StErr1;
`endif
        end
      end
      StErr1: begin
        ahb3_hready_o = 1'b0;
        ahb3_hresp_o  = 1'b1;
        state_d       = StErr2;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef MPI_AHB3_BRIDGE_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end
`endif

endmodule
